// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit holding the MIPS HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit work register.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t             state, state_next;
    logic [4:0]         cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               zero_div;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   orig_rs;
    logic [2*WIDTH-1:0] work;

    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     trial;
    logic               trial_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot, rem;

    // Signed ops (op[0]==0) work on magnitudes; signs are fixed up in FINISH.
    assign rs_neg = !op[0] && rs_data[WIDTH-1];
    assign rt_neg = !op[0] && rt_data[WIDTH-1];
    assign rs_abs = rs_neg ? -rs_data : rs_data;
    assign rt_abs = rt_neg ? -rt_data : rt_data;

    assign add_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
    assign mult_next = {add_sum, work[WIDTH-1:1]};

    // The shifted-in partial remainder can need WIDTH+1 bits when the divisor exceeds 2^(WIDTH-1).
    assign partial  = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign trial    = partial - {1'b0, operand};
    assign trial_ok = partial >= {1'b0, operand};
    assign div_next = trial_ok ? {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                               : {partial[WIDTH-1:0], work[WIDTH-2:0], 1'b0};

    assign product = neg_res ? -work : work;
    assign quot    = neg_res ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign rem     = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == 5'(WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
            operand     <= '0;
            orig_rs     <= '0;
            work        <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        zero_div <= op[1] && (rt_data == '0);
                        orig_rs  <= rs_data;
                        operand  <= op[1] ? rt_abs : rs_abs;
                        work     <= op[1] ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    work <= is_div ? div_next : mult_next;
                    cnt  <= cnt + 5'd1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end else if (zero_div) begin
                        hi          <= orig_rs;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem;
                        lo <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed results, latency,
// busy-time blocking of start/mthi and mid-operation reset.
module tb_muldiv_unit;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;
    int busy_count;
    logic got_done, dz_seen;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge so the rising edge sees them settled.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0;
        busy_count = 0;
        got_done   = 1'b0;
        dz_seen    = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 60 && !got_done; i++) begin
            if (busy) busy_count++;
            if (done) begin
                got_done = 1'b1;
                dz_seen  = div_by_zero;
                checkOutput("busy_at_done", 64'(busy), 64'd0);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic finishChecks(input string tag, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input logic exp_dz);
        checkOutput({tag, "_done"}, 64'(got_done), 64'd1);
        checkOutput({tag, "_busy_cycles"}, 64'(busy_count), 64'd33);
        checkOutput({tag, "_dz"}, 64'(dz_seen), 64'(exp_dz));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz);
        applyStimulus(o, a, b);
        waitDone();
        finishChecks(tag, exp_hi, exp_lo, exp_dz);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;

        // Moves in IDLE, including both at once.
        @(negedge clk); mthi = 1'b1; rs_data = 32'h0000_1111;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; rs_data = 32'h0000_2222;
        @(negedge clk); mtlo = 1'b0;
        checkOutput("mthi_hi", 64'(hi), 64'h1111);
        checkOutput("mtlo_lo", 64'(lo), 64'h2222);
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h0000_0055;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        checkOutput("mthilo_hi", 64'(hi), 64'h55);
        checkOutput("mthilo_lo", 64'(lo), 64'h55);

        runOp("mult_4x2",      MULT,  32'd4,          32'd2,          32'h0,          32'h8,          1'b0);
        runOp("multu_ffxff",   MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0);
        runOp("mult_m1xm1",    MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h1,          1'b0);
        runOp("mult_m3x5",     MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  1'b0);
        runOp("div_m7by2",     DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0);
        runOp("divu_10by3",    DIVU,  32'd10,         32'd3,          32'd1,          32'd3,          1'b0);
        runOp("divu_big",      DIVU,  32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  32'd1,          1'b0);
        runOp("divu_by0",      DIVU,  32'h0000_000A,  32'd0,          32'h0000_000A,  32'hFFFF_FFFF,  1'b1);
        runOp("div_m5by0",     DIV,   32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  1'b1);
        runOp("div_overflow",  DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0);

        // start and mthi while busy must both be ignored.
        applyStimulus(MULTU, 32'd5, 32'd6);
        for (int i = 0; i < 9; i++) begin
            if (busy) busy_count++;
            @(negedge clk);
        end
        start = 1'b1; mthi = 1'b1; op = DIV; rs_data = 32'h1234; rt_data = 32'd7;
        if (busy) busy_count++;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        waitDone();
        finishChecks("busy_ignore", 32'h0, 32'd30, 1'b0);

        // Reset mid-division aborts without a result or done pulse.
        mthi = 1'b1; rs_data = 32'h0000_AAAA;
        @(negedge clk); mthi = 1'b0;
        checkOutput("preload_hi", 64'(hi), 64'hAAAA);
        applyStimulus(DIV, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) got_done = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 64'(got_done), 64'd0);
        runOp("after_reset_3x3", MULTU, 32'd3, 32'd3, 32'h0, 32'd9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
